// File: rtl/imm16_assembler_if.sv
// Handshake bundle between the shift-by-8 stage, the immediate
// assembler and the register-write/ALU-B consumer.
interface imm16_assembler_if;
  logic [15:0] upper_in;
  logic        upper_valid;
  logic [7:0]  lower_in;
  logic        lower_valid;
  logic        sign_ext;
  logic        out_ready;
  logic [15:0] imm_out;
  logic        imm_valid;
  logic        busy;

  modport master (
    output upper_in, upper_valid,
    output lower_in, lower_valid,
    output sign_ext, out_ready,
    input  imm_out, imm_valid, busy
  );

  modport slave (
    input  upper_in, upper_valid,
    input  lower_in, lower_valid,
    input  sign_ext, out_ready,
    output imm_out, imm_valid, busy
  );
endinterface

// File: rtl/imm16_assembler.sv
// Merges an upper-byte-aligned word and a lower immediate byte into
// one 16-bit immediate, with lone-lower extension and upper timeout.
module imm16_assembler #(
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  imm16_assembler_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    UPPER_HELD,
    OUT_VALID
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  logic [7:0]       held_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      imm_q;
  logic             valid_q;
  logic             busy_q;

  logic [15:0] lo_ext_d;
  logic        unused_lo;

  assign lo_ext_d = {{8{bus.sign_ext & bus.lower_in[7]}},
                     bus.lower_in};

  // The shift stage leaves its low byte undefined.
  assign unused_lo = ^bus.upper_in[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= 8'h00;
      cnt_q   <= '0;
      imm_q   <= 16'h0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.upper_valid && bus.lower_valid) begin
            imm_q   <= {bus.upper_in[15:8], bus.lower_in};
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OUT_VALID;
          end else if (bus.upper_valid) begin
            held_q  <= bus.upper_in[15:8];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= UPPER_HELD;
          end else if (bus.lower_valid) begin
            imm_q   <= lo_ext_d;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OUT_VALID;
          end
        end
        UPPER_HELD: begin
          // A lower byte always pairs with the byte already held.
          if (bus.lower_valid) begin
            imm_q   <= {held_q, bus.lower_in};
            valid_q <= 1'b1;
            state_q <= OUT_VALID;
          end else if (bus.upper_valid) begin
            held_q <= bus.upper_in[15:8];
            cnt_q  <= '0;
          end else if (cnt_q == TO_LAST) begin
            imm_q   <= {held_q, 8'h00};
            valid_q <= 1'b1;
            state_q <= OUT_VALID;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        OUT_VALID: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.imm_out   = imm_q;
  assign bus.imm_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_imm16_assembler.sv
// Directed and randomized checks of imm16_assembler against a
// cycle-level behavioural model.
module tb_imm16_assembler;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imm16_assembler_if bus ();

  imm16_assembler #(
    .TIMEOUT(TO),
    .CNT_W  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what the assembler is doing, in plain terms.
  bit        m_have_up;
  bit        m_pending;
  bit [7:0]  m_hold;
  int        m_quiet;
  bit [15:0] m_out;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic emit(input bit [15:0] v);
    m_out     = v;
    m_pending = 1'b1;
    m_have_up = 1'b0;
  endtask

  task automatic model_step();
    int lo;
    lo = int'(bus.lower_in);
    if (reset) begin
      m_have_up = 0;
      m_pending = 0;
      m_hold    = 0;
      m_quiet   = 0;
      m_out     = 0;
    end else if (m_pending) begin
      if (bus.out_ready) m_pending = 0;
    end else if (m_have_up) begin
      if (bus.lower_valid) begin
        emit(16'(int'(m_hold) * 256 + lo));
      end else if (bus.upper_valid) begin
        m_hold  = bus.upper_in[15:8];
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TO) emit(16'(int'(m_hold) * 256));
      end
    end else if (bus.upper_valid && bus.lower_valid) begin
      emit(16'(int'(bus.upper_in[15:8]) * 256 + lo));
    end else if (bus.upper_valid) begin
      m_have_up = 1;
      m_hold    = bus.upper_in[15:8];
      m_quiet   = 0;
    end else if (bus.lower_valid) begin
      if (bus.sign_ext && lo >= 128) emit(16'(65536 - 256 + lo));
      else emit(16'(lo));
    end
  endtask

  task automatic cyc(input logic [15:0] u, input logic uv,
                     input logic [7:0] l, input logic lv,
                     input logic se, input logic rdy,
                     input logic rst);
    reset           = rst;
    bus.upper_in    = u;
    bus.upper_valid = uv;
    bus.lower_in    = l;
    bus.lower_valid = lv;
    bus.sign_ext    = se;
    bus.out_ready   = rdy;
    @(posedge clk);
    model_step();
    #1;
    chk("valid", 16'(bus.imm_valid), 16'(m_pending));
    chk("busy", 16'(bus.busy), 16'(m_pending | m_have_up));
    chk("imm", bus.imm_out, m_out);
  endtask

  task automatic idle(input logic rdy);
    cyc(16'h0, 1'b0, 8'h0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    int n;
    m_have_up = 0;
    m_pending = 0;
    m_hold    = 0;
    m_quiet   = 0;
    m_out     = 0;

    // 1: reset
    cyc(16'h0, 0, 8'h0, 0, 0, 0, 1);
    cyc(16'h0, 0, 8'h0, 0, 0, 0, 1);
    idle(0);
    chk("t1_imm", bus.imm_out, 16'h0000);
    chk("t1_valid", 16'(bus.imm_valid), 16'h0);
    chk("t1_busy", 16'(bus.busy), 16'h0);

    // 2: upper then lower
    cyc(16'h1600, 1, 8'h00, 0, 0, 1, 0);
    chk("t2_busy", 16'(bus.busy), 16'h1);
    cyc(16'h0000, 0, 8'h34, 1, 0, 1, 0);
    chk("t2_imm", bus.imm_out, 16'h1634);
    chk("t2_valid", 16'(bus.imm_valid), 16'h1);
    idle(1);
    chk("t2_drop", 16'(bus.imm_valid), 16'h0);

    // 3: lone lower and same-cycle pair
    cyc(16'h0, 0, 8'hF0, 1, 1, 1, 0);
    chk("t3_sext", bus.imm_out, 16'hFFF0);
    idle(1);
    cyc(16'h0, 0, 8'hF0, 1, 0, 1, 0);
    chk("t3_zext", bus.imm_out, 16'h00F0);
    idle(1);
    cyc(16'hAB00, 1, 8'hCD, 1, 1, 1, 0);
    chk("t3_pair", bus.imm_out, 16'hABCD);
    idle(1);

    // 4: timeout and restart
    cyc(16'hFF00, 1, 8'h00, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10 && !bus.imm_valid; i++) begin
      idle(0);
      n++;
    end
    chk("t4_lat", 16'(n), 16'(TO));
    chk("t4_imm", bus.imm_out, 16'hFF00);
    idle(1);
    cyc(16'hFF00, 1, 8'h00, 0, 0, 0, 0);
    idle(0);
    cyc(16'h2200, 1, 8'h00, 0, 0, 0, 0);
    n = 0;
    for (int i = 0; i < 10 && !bus.imm_valid; i++) begin
      idle(0);
      n++;
    end
    chk("t4_rlat", 16'(n), 16'(TO));
    chk("t4_rimm", bus.imm_out, 16'h2200);
    idle(1);

    // 5: backpressure
    cyc(16'h1600, 1, 8'h00, 0, 0, 0, 0);
    cyc(16'h0000, 0, 8'h34, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(16'h5500, i[0], 8'h77, ~i[0], 1, 0, 0);
      chk("t5_imm", bus.imm_out, 16'h1634);
      chk("t5_valid", 16'(bus.imm_valid), 16'h1);
      chk("t5_busy", 16'(bus.busy), 16'h1);
    end
    idle(1);
    chk("t5_acc", 16'(bus.imm_valid), 16'h0);
    idle(1);
    chk("t5_once", 16'(bus.imm_valid), 16'h0);

    // 6: reset while holding an upper byte
    cyc(16'h7700, 1, 8'h00, 0, 0, 0, 0);
    cyc(16'h0000, 0, 8'h00, 0, 0, 0, 1);
    chk("t6_valid", 16'(bus.imm_valid), 16'h0);
    chk("t6_busy", 16'(bus.busy), 16'h0);
    idle(0);
    idle(0);
    cyc(16'h0000, 0, 8'h01, 1, 0, 1, 0);
    chk("t6_imm", bus.imm_out, 16'h0001);
    idle(1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(16'($urandom), ($urandom_range(0, 3) == 0),
          8'($urandom), ($urandom_range(0, 5) == 0),
          1'($urandom), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 60) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
